// File: rtl/code_dumper_if.sv
// Code RAM read port plus UART transmit handshake used by the code dumper.
// The dumper is the master: it drives the RAM address and the byte/pulse
// toward the UART, and receives the RAM data and the transmitter status.
interface code_dumper_if #(
  parameter int addrSize_code = 9
);
  logic [addrSize_code-1:0] addrCode;
  logic [7:0]               codeIn;
  logic [7:0]               data_tx;
  logic                     start_transmit;
  logic                     tx_ready;

  modport master (
    output addrCode,
    input  codeIn,
    output data_tx,
    output start_transmit,
    input  tx_ready
  );

  modport slave (
    input  addrCode,
    output codeIn,
    input  data_tx,
    input  start_transmit,
    output tx_ready
  );
endinterface

// File: rtl/code_dumper.sv
// Code dumper: walks the code RAM from address 0 and streams each byte to the
// UART transmitter so the host can read back a loaded program. With
// stopOnNull set, the first 0x00 byte terminates the dump without being sent.
module code_dumper #(
  parameter int addrSize_code = 9,
  parameter bit stopOnNull    = 1'b1
) (
  input  logic                   sysClk,
  input  logic                   reset,
  input  logic                   start,
  code_dumper_if.master          codeBus,
  output logic                   busy,
  output logic                   done,
  output logic [addrSize_code:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    SEND,
    WAIT_ACK,
    WAIT_TX,
    DONE
  } stateType;

  localparam logic [addrSize_code-1:0] lastAddr = {addrSize_code{1'b1}};

  stateType state;

  // Dump sequencer. CHECK also waits for tx_ready high so a pulse is never
  // issued while the transmitter is still busy (e.g. right after a reset
  // that cut a previous byte short).
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      codeBus.addrCode       <= '0;
      codeBus.data_tx        <= 8'h00;
      codeBus.start_transmit <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      count                  <= '0;
    end else begin
      codeBus.start_transmit <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            codeBus.addrCode <= '0;
            count            <= '0;
            done             <= 1'b0;
            busy             <= 1'b1;
            state            <= FETCH;
          end
        end
        FETCH: begin
          state <= CHECK;
        end
        CHECK: begin
          if (stopOnNull && (codeBus.codeIn == 8'h00)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (codeBus.tx_ready) begin
            codeBus.data_tx        <= codeBus.codeIn;
            codeBus.start_transmit <= 1'b1;
            state                  <= SEND;
          end
        end
        SEND: begin
          count <= count + 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!codeBus.tx_ready) begin
            state <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (codeBus.tx_ready) begin
            if (codeBus.addrCode == lastAddr) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              codeBus.addrCode <= codeBus.addrCode + 1'b1;
              state            <= FETCH;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_dumper.sv
// Testbench for code_dumper: two instances (9-bit RAM stopping on null, and
// 3-bit RAM dumping everything), each with a synchronous RAM model, a UART
// model that acknowledges pulses, and a scoreboard of expected bytes.
module tb_code_dumper;

  logic sysClk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 sysClk = ~sysClk;

  // Instance A: 512-byte RAM, stopOnNull=1
  logic       startA;
  logic       busyA, doneA;
  logic [9:0] countA;
  logic [7:0] ramA [0:511];
  logic [7:0] expA [$];
  logic [7:0] expByteA;
  int         pulsesA = 0;
  int         pulseNumA = 0;
  int         slowIdxA = 0;

  code_dumper_if #(.addrSize_code(9)) busA ();

  code_dumper #(.addrSize_code(9), .stopOnNull(1'b1)) dutA (
    .sysClk (sysClk),
    .reset  (reset),
    .start  (startA),
    .codeBus(busA),
    .busy   (busyA),
    .done   (doneA),
    .count  (countA)
  );

  // Instance B: 8-byte RAM, stopOnNull=0
  logic       startB;
  logic       busyB, doneB;
  logic [3:0] countB;
  logic [7:0] ramB [0:7];
  logic [7:0] expB [$];
  logic [7:0] expByteB;
  int         pulsesB = 0;

  code_dumper_if #(.addrSize_code(3)) busB ();

  code_dumper #(.addrSize_code(3), .stopOnNull(1'b0)) dutB (
    .sysClk (sysClk),
    .reset  (reset),
    .start  (startB),
    .codeBus(busB),
    .busy   (busyB),
    .done   (doneB),
    .count  (countB)
  );

  // Synchronous-read RAM models
  always @(posedge sysClk) busA.codeIn <= ramA[busA.addrCode];
  always @(posedge sysClk) busB.codeIn <= ramB[busB.addrCode];

  // UART model A: busy 3 cycles after a pulse, low for 20 (or 500 for the slow pulse)
  initial begin
    busA.tx_ready = 1'b1;
    forever begin
      @(negedge sysClk);
      if (busA.start_transmit === 1'b1) begin
        pulseNumA++;
        repeat (3) @(negedge sysClk);
        busA.tx_ready = 1'b0;
        repeat ((pulseNumA == slowIdxA) ? 500 : 20) @(negedge sysClk);
        busA.tx_ready = 1'b1;
      end
    end
  end

  // UART model B: same shape, always 20 cycles busy
  initial begin
    busB.tx_ready = 1'b1;
    forever begin
      @(negedge sysClk);
      if (busB.start_transmit === 1'b1) begin
        repeat (3) @(negedge sysClk);
        busB.tx_ready = 1'b0;
        repeat (20) @(negedge sysClk);
        busB.tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard A: every pulse must carry the next expected byte while tx_ready is high
  always @(negedge sysClk) begin
    if (reset === 1'b1 && busA.start_transmit === 1'b1) begin
      pulsesA++;
      vectors++;
      if (expA.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL pulseDataA: got byte %02h, expected no pulse", busA.data_tx);
      end else begin
        expByteA = expA.pop_front();
        if (busA.data_tx !== expByteA) begin
          miscompares++;
          $display("[TB] FAIL pulseDataA: got %02h expected %02h", busA.data_tx, expByteA);
        end
      end
      vectors++;
      if (busA.tx_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL pulseTxReadyA: got tx_ready %b expected 1", busA.tx_ready);
      end
    end
  end

  // Scoreboard B
  always @(negedge sysClk) begin
    if (reset === 1'b1 && busB.start_transmit === 1'b1) begin
      pulsesB++;
      vectors++;
      if (expB.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL pulseDataB: got byte %02h, expected no pulse", busB.data_tx);
      end else begin
        expByteB = expB.pop_front();
        if (busB.data_tx !== expByteB) begin
          miscompares++;
          $display("[TB] FAIL pulseDataB: got %02h expected %02h", busB.data_tx, expByteB);
        end
      end
    end
  end

  task automatic applyStimulusLoadA();
    for (int i = 0; i < 512; i++) ramA[i] = 8'h00;
    ramA[0] = 8'h2B;
    ramA[1] = 8'h2E;
    ramA[2] = 8'h3E;
    ramA[3] = 8'h00;
  endtask

  task automatic pushProgramA();
    expA.push_back(8'h2B);
    expA.push_back(8'h2E);
    expA.push_back(8'h3E);
  endtask

  task automatic pulseStartA();
    @(negedge sysClk);
    startA = 1'b1;
    @(negedge sysClk);
    startA = 1'b0;
  endtask

  task automatic pulseStartB();
    @(negedge sysClk);
    startB = 1'b1;
    @(negedge sysClk);
    startB = 1'b0;
  endtask

  task automatic waitDoneA(input int maxCycles, output bit gotDone);
    int n = 0;
    while (doneA !== 1'b1 && n < maxCycles) begin
      @(negedge sysClk);
      n++;
    end
    gotDone = (doneA === 1'b1);
  endtask

  task automatic waitDoneB(input int maxCycles, output bit gotDone);
    int n = 0;
    while (doneB !== 1'b1 && n < maxCycles) begin
      @(negedge sysClk);
      n++;
    end
    gotDone = (doneB === 1'b1);
  endtask

  task automatic waitPulsesA(input int target, input int maxCycles);
    int n = 0;
    while (pulsesA < target && n < maxCycles) begin
      @(negedge sysClk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    repeat (2) @(negedge sysClk);
    vectors++;
    if (busA.addrCode !== 9'd0) begin miscompares++; $display("[TB] FAIL resetAddrA: got %0h expected 0", busA.addrCode); end
    vectors++;
    if (busA.data_tx !== 8'h00) begin miscompares++; $display("[TB] FAIL resetDataA: got %02h expected 00", busA.data_tx); end
    vectors++;
    if (busA.start_transmit !== 1'b0) begin miscompares++; $display("[TB] FAIL resetPulseA: got %b expected 0", busA.start_transmit); end
    vectors++;
    if ({busyA, doneA} !== 2'b00) begin miscompares++; $display("[TB] FAIL resetBusyDoneA: got %b expected 00", {busyA, doneA}); end
    vectors++;
    if (countA !== 10'd0) begin miscompares++; $display("[TB] FAIL resetCountA: got %0d expected 0", countA); end
    vectors++;
    if ({busB.addrCode, countB, busyB, doneB} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL resetStateB: got addr %0d count %0d busy %b done %b expected all 0", busB.addrCode, countB, busyB, doneB);
    end
    @(negedge sysClk);
    reset = 1'b1;
  endtask

  task automatic test_basic_dump();
    bit gotDone;
    applyStimulusLoadA();
    pulsesA = 0;
    pushProgramA();
    pulseStartA();
    waitDoneA(2000, gotDone);
    vectors++;
    if (gotDone !== 1'b1) begin miscompares++; $display("[TB] FAIL basicDoneA: got %b expected 1", gotDone); end
    vectors++;
    if (countA !== 10'd3) begin miscompares++; $display("[TB] FAIL basicCountA: got %0d expected 3", countA); end
    vectors++;
    if (busA.addrCode !== 9'd3) begin miscompares++; $display("[TB] FAIL basicAddrA: got %0d expected 3", busA.addrCode); end
    vectors++;
    if (busyA !== 1'b0) begin miscompares++; $display("[TB] FAIL basicBusyA: got %b expected 0", busyA); end
    vectors++;
    if (pulsesA !== 3 || expA.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL basicPulsesA: got %0d pulses (%0d pending) expected 3 (0 pending)", pulsesA, expA.size());
    end
  endtask

  task automatic test_null_first();
    applyStimulusLoadA();
    ramA[0] = 8'h00;
    pulsesA = 0;
    @(negedge sysClk);
    startA = 1'b1;
    @(negedge sysClk);
    startA = 1'b0;
    vectors++;
    if ({busyA, doneA} !== 2'b10) begin miscompares++; $display("[TB] FAIL nullFetchA: got busy/done %b expected 10", {busyA, doneA}); end
    @(negedge sysClk);
    vectors++;
    if (doneA !== 1'b0) begin miscompares++; $display("[TB] FAIL nullCheckA: got done %b expected 0", doneA); end
    @(negedge sysClk);
    vectors++;
    if ({busyA, doneA} !== 2'b01) begin miscompares++; $display("[TB] FAIL nullDoneA: got busy/done %b expected 01", {busyA, doneA}); end
    vectors++;
    if (countA !== 10'd0 || busA.addrCode !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL nullCountA: got count %0d addr %0d expected 0 0", countA, busA.addrCode);
    end
    repeat (5) @(negedge sysClk);
    vectors++;
    if (pulsesA !== 0) begin miscompares++; $display("[TB] FAIL nullPulsesA: got %0d expected 0", pulsesA); end
  endtask

  task automatic test_slow_ack();
    bit gotDone;
    bit dataMoved = 1'b0;
    applyStimulusLoadA();
    pulsesA   = 0;
    pulseNumA = 0;
    slowIdxA  = 2;
    pushProgramA();
    pulseStartA();
    waitPulsesA(2, 300);
    vectors++;
    if (pulsesA !== 2) begin miscompares++; $display("[TB] FAIL slowSecondPulseA: got %0d pulses expected 2", pulsesA); end
    for (int i = 0; i < 490; i++) begin
      @(negedge sysClk);
      if (busA.data_tx !== 8'h2E) dataMoved = 1'b1;
    end
    vectors++;
    if (pulsesA !== 2) begin miscompares++; $display("[TB] FAIL slowHoldPulsesA: got %0d pulses expected 2", pulsesA); end
    vectors++;
    if (dataMoved !== 1'b0) begin miscompares++; $display("[TB] FAIL slowHoldDataA: got data change %b expected 0", dataMoved); end
    waitDoneA(1500, gotDone);
    vectors++;
    if (gotDone !== 1'b1 || countA !== 10'd3 || pulsesA !== 3) begin
      miscompares++;
      $display("[TB] FAIL slowFinishA: got done %b count %0d pulses %0d expected 1 3 3", gotDone, countA, pulsesA);
    end
    slowIdxA = 0;
  endtask

  task automatic test_reset_mid();
    bit gotDone;
    applyStimulusLoadA();
    pulsesA   = 0;
    pulseNumA = 0;
    pushProgramA();
    pulseStartA();
    waitPulsesA(2, 300);
    repeat (10) @(negedge sysClk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (busA.addrCode !== 9'd0 || busA.data_tx !== 8'h00 || busA.start_transmit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midResetBusA: got addr %0d data %02h pulse %b expected 0 00 0", busA.addrCode, busA.data_tx, busA.start_transmit);
    end
    vectors++;
    if (busyA !== 1'b0 || doneA !== 1'b0 || countA !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL midResetCtrlA: got busy %b done %b count %0d expected 0 0 0", busyA, doneA, countA);
    end
    expA.delete();
    @(negedge sysClk);
    reset   = 1'b1;
    startA  = 1'b1;
    pulsesA = 0;
    pushProgramA();
    @(negedge sysClk);
    startA = 1'b0;
    vectors++;
    if (busyA !== 1'b1 || busA.addrCode !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL midRestartA: got busy %b addr %0d expected 1 0", busyA, busA.addrCode);
    end
    waitDoneA(2000, gotDone);
    vectors++;
    if (gotDone !== 1'b1 || countA !== 10'd3 || pulsesA !== 3 || busA.addrCode !== 9'd3) begin
      miscompares++;
      $display("[TB] FAIL midRedumpA: got done %b count %0d pulses %0d addr %0d expected 1 3 3 3", gotDone, countA, pulsesA, busA.addrCode);
    end
  endtask

  task automatic test_back_to_back();
    bit gotDone;
    applyStimulusLoadA();
    pulsesA = 0;
    pushProgramA();
    pushProgramA();
    @(negedge sysClk);
    startA = 1'b1;
    @(negedge sysClk);
    waitDoneA(2000, gotDone);
    vectors++;
    if (gotDone !== 1'b1 || pulsesA !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2bFirstA: got done %b pulses %0d expected 1 3", gotDone, pulsesA);
    end
    @(negedge sysClk);
    vectors++;
    if (doneA !== 1'b0 || busyA !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2bRestartA: got done %b busy %b expected 0 1", doneA, busyA);
    end
    waitDoneA(2000, gotDone);
    startA = 1'b0;
    vectors++;
    if (gotDone !== 1'b1 || pulsesA !== 6 || countA !== 10'd3 || expA.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL b2bSecondA: got done %b pulses %0d count %0d pending %0d expected 1 6 3 0", gotDone, pulsesA, countA, expA.size());
    end
    repeat (3) @(negedge sysClk);
    vectors++;
    if (doneA !== 1'b1 || busyA !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2bStopA: got done %b busy %b expected 1 0", doneA, busyA);
    end
  endtask

  task automatic test_full_ram();
    bit gotDone;
    pulsesB = 0;
    for (int i = 0; i < 8; i++) begin
      ramB[i] = 8'(i + 1);
      expB.push_back(8'(i + 1));
    end
    pulseStartB();
    waitDoneB(1000, gotDone);
    vectors++;
    if (gotDone !== 1'b1) begin miscompares++; $display("[TB] FAIL fullDoneB: got %b expected 1", gotDone); end
    vectors++;
    if (countB !== 4'd8) begin miscompares++; $display("[TB] FAIL fullCountB: got %0d expected 8", countB); end
    vectors++;
    if (pulsesB !== 8 || expB.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL fullPulsesB: got %0d pulses (%0d pending) expected 8 (0 pending)", pulsesB, expB.size());
    end
    repeat (5) @(negedge sysClk);
    vectors++;
    if (busB.addrCode !== 3'd7 || doneB !== 1'b1 || busyB !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fullNoWrapB: got addr %0d done %b busy %b expected 7 1 0", busB.addrCode, doneB, busyB);
    end
  endtask

  task automatic test_null_payload();
    bit gotDone;
    pulsesB = 0;
    for (int i = 0; i < 8; i++) begin
      ramB[i] = (i == 3) ? 8'h00 : 8'(8'hA0 + i);
      expB.push_back((i == 3) ? 8'h00 : 8'(8'hA0 + i));
    end
    pulseStartB();
    waitDoneB(1000, gotDone);
    vectors++;
    if (gotDone !== 1'b1 || countB !== 4'd8 || pulsesB !== 8 || expB.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL nullPayloadB: got done %b count %0d pulses %0d pending %0d expected 1 8 8 0", gotDone, countB, pulsesB, expB.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_null_first();
    test_slow_ack();
    test_reset_mid();
    test_back_to_back();
    test_full_ram();
    test_null_payload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/code_dumper.md
Name: code_dumper

Overview:
- Read-back counterpart of the code loader.
- Walks the code RAM from address 0 and streams each byte out through the UART transmit handshake (data_tx / start_transmit / tx_ready), so the host can verify a loaded program.
- Sits beside the loader on the code RAM's processor-side read port; top-level muxes its UART outputs the same way as the loader loop-back and the core.

Parameters:
- addrSize_code, 9, code RAM address width; depth = 2^addrSize_code bytes.
- stopOnNull, 1, when 1 a 0x00 byte ends the dump without being sent; when 0 the whole RAM is sent.

Ports:
- sysClk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; low forces reset state immediately.
- start  in  1  level sampled each cycle; high in IDLE or DONE begins a dump.
- addrCode  out  addrSize_code  code RAM read address.
- codeIn  in  8  code RAM read data, valid one cycle after addrCode changes (synchronous read).
- data_tx  out  8  byte to transmit; stable from the start_transmit pulse until tx_ready returns high.
- start_transmit  out  1  one-cycle pulse requesting a UART send.
- tx_ready  in  1  UART transmitter idle (high) / busy (low).
- busy  out  1  high from the first FETCH until DONE.
- done  out  1  high in DONE; cleared by a new start or by reset.
- count  out  addrSize_code+1  number of bytes sent in the current or last dump.

Behaviour:
- Reset (reset low, async): state IDLE; addrCode=0, data_tx=0x00, start_transmit=0, busy=0, done=0, count=0.
- States: IDLE, FETCH, CHECK, SEND, WAIT_ACK, WAIT_TX, DONE.
- IDLE/DONE and start=1: next cycle addrCode=0, count=0, done=0, busy=1, state FETCH.
- start is ignored in every other state.
- FETCH: 1 cycle for RAM latency, then CHECK.
- CHECK: codeIn valid.
  - stopOnNull=1 and codeIn==0x00: go to DONE; nothing is sent.
  - Otherwise: data_tx<=codeIn, go to SEND.
- SEND: start_transmit=1 for exactly this cycle; count<=count+1; then WAIT_ACK.
- WAIT_ACK: stay until tx_ready==0, the UART acknowledging through the clock-domain catcher. Any number of cycles is allowed.
- WAIT_TX: stay until tx_ready==1.
  - If addrCode == 2^addrSize_code-1: go to DONE; no address wrap.
  - Else addrCode<=addrCode+1, go to FETCH.
- DONE: busy=0, done=1, addrCode holds the last address read.
- Throughput: at most one byte per UART frame. start_transmit is never asserted while tx_ready is low or before the previous byte's WAIT_TX completes.
- Byte at address 0 is 0x00 with stopOnNull=1: DONE reached 2 cycles after FETCH entry, count=0, no pulse.
- Full RAM with no null: count = 2^addrSize_code (hence the extra count bit).
- Reset mid-dump: immediate return to reset state. A pulse in flight is truncated; the UART may still finish a byte already accepted.
- start held high continuously: one dump per DONE→restart; a new dump begins the cycle after DONE is entered.
- tx_ready low on entry to FETCH is legal; the wait states handle ordering.
- Requirement on the partner: tx_ready must stay low ≥1 sysClk cycle per frame.

Test Plan:
- RAM = "+.>" 0x00 (0x2B,0x2E,0x3E,0x00), stopOnNull=1, UART model drops tx_ready 3 cycles after pulse and holds it low 20 cycles -> exactly 3 start_transmit pulses with data_tx 0x2B,0x2E,0x3E in order; done=1, count=3, addrCode=3.
- RAM[0]=0x00, stopOnNull=1 -> no start_transmit; done=1 and busy=0 two cycles after FETCH; count=0.
- addrSize_code=3, stopOnNull=0, RAM filled 0x01..0x08 -> 8 pulses carrying 0x01..0x08; addrCode stops at 7 with no wrap; count=8.
- tx_ready held low for 500 cycles after the 2nd pulse -> no 3rd pulse until tx_ready rises; data_tx stays 0x2E throughout.
- reset driven low asynchronously during WAIT_TX of byte 2 -> all outputs 0 within the same cycle; after release with start=1 the dump restarts from addrCode=0.
- start held high for the whole run -> after DONE the block re-dumps identical bytes; done pulses high for one cycle between the dumps.
